// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one four-phase REQ/ACK memory port among NREQ requesters.
// Latency: M_REQ one edge after REQ_I is sampled in IDLE; ACK_O two edges after grant with a 1-cycle memory.
// Backpressure: grant held until REQ_I[g] and M_ACK are both low; ARB_TIMEOUT_EN adds an M_ACK timeout with ERR_O.
module mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ_I,
    input  logic [NREQ-1:0]      WEN_I,
    input  logic [NREQ*AW-1:0]   ADDR_I,
    input  logic [NREQ*DW-1:0]   DIN_I,
    output logic [NREQ-1:0]      ACK_O,
    output logic [DW-1:0]        DOUT_O,
    output logic [NREQ-1:0]      GNT_O,
    output logic                 ERR_O,
    output logic                 M_REQ,
    output logic                 M_WEN,
    output logic [AW-1:0]        M_ADDR,
    output logic [DW-1:0]        M_DIN,
    input  logic [DW-1:0]        M_DOUT,
    input  logic                 M_ACK
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_ptr, w_ptr_nxt;
    logic [PW-1:0]   r_gidx, w_gidx_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_ack, w_ack_nxt;
    logic [DW-1:0]   r_dout, w_dout_nxt;
    logic            r_m_req, w_m_req_nxt;
    logic            r_m_wen, w_m_wen_nxt;
    logic [AW-1:0]   r_m_addr, w_m_addr_nxt;
    logic [DW-1:0]   r_m_din, w_m_din_nxt;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic            r_err, w_err_nxt;
    logic            w_tmo;
`endif

    logic            w_found;
    logic [PW-1:0]   w_sel;
    logic [PW-1:0]   w_k;

    // Round-robin search: first requester at or after the pointer, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_k     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_k = PW'((int'(r_ptr) + i) % NREQ);
            if (!w_found && REQ_I[w_k]) begin
                w_found = 1'b1;
                w_sel   = w_k;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Fires on the ISSUE cycle where the wait counter would reach TIMEOUT
    assign w_tmo = (({1'b0, r_cnt} + 9'd1) == 9'(TIMEOUT));
`endif

    // Next-state and next-output logic for the IDLE/ISSUE/RESP sequence
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_gidx_nxt   = r_gidx;
        w_gnt_nxt    = r_gnt;
        w_ack_nxt    = r_ack;
        w_dout_nxt   = r_dout;
        w_m_req_nxt  = r_m_req;
        w_m_wen_nxt  = r_m_wen;
        w_m_addr_nxt = r_m_addr;
        w_m_din_nxt  = r_m_din;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                // M_ACK guard: a memory still finishing a handshake from before a reset
                if (w_found && !M_ACK) begin
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_sel] = 1'b1;
                    w_gidx_nxt       = w_sel;
                    w_m_req_nxt      = 1'b1;
                    w_m_wen_nxt      = WEN_I[w_sel];
                    w_m_addr_nxt     = ADDR_I[int'(w_sel)*AW +: AW];
                    w_m_din_nxt      = DIN_I[int'(w_sel)*DW +: DW];
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt        = '0;
`endif
                    w_state_nxt      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (M_ACK) begin
                    w_m_req_nxt = 1'b0;
                    w_m_wen_nxt = 1'b0;
                    w_ack_nxt   = r_gnt;
                    // Read data is captured only for reads; writes leave DOUT_O alone
                    if (!r_m_wen) begin
                        w_dout_nxt = M_DOUT;
                    end
`ifdef ARB_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
`endif
                    w_state_nxt = S_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (w_tmo) begin
                    w_m_req_nxt = 1'b0;
                    w_ack_nxt   = r_gnt;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
`endif
            end
            S_RESP: begin
                // Both the requester and the memory must have released before the grant ends
                if (!REQ_I[r_gidx] && !M_ACK) begin
                    w_ack_nxt   = '0;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = PW'((int'(r_gidx) + 1) % NREQ);
`ifdef ARB_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
`endif
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_gidx   <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_dout   <= '0;
            r_m_req  <= 1'b0;
            r_m_wen  <= 1'b0;
            r_m_addr <= '0;
            r_m_din  <= '0;
`ifdef ARB_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gidx   <= w_gidx_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ack    <= w_ack_nxt;
            r_dout   <= w_dout_nxt;
            r_m_req  <= w_m_req_nxt;
            r_m_wen  <= w_m_wen_nxt;
            r_m_addr <= w_m_addr_nxt;
            r_m_din  <= w_m_din_nxt;
`ifdef ARB_TIMEOUT_EN
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
`endif
        end
    end

    assign GNT_O  = r_gnt;
    assign ACK_O  = r_ack;
    assign DOUT_O = r_dout;
    assign M_REQ  = r_m_req;
    assign M_WEN  = r_m_wen;
    assign M_ADDR = r_m_addr;
    assign M_DIN  = r_m_din;
`ifdef ARB_TIMEOUT_EN
    assign ERR_O  = r_err;
`else
    assign ERR_O  = 1'b0;
`endif

endmodule
